// File: rtl/imem_rtype_responder.sv
// Instruction-memory stand-in: answers fetches with NOPs during warmup, then with
// pseudo-random legal RV32I R-type words drawn from a Galois LFSR, via a 2-entry FIFO.
module imem_rtype_responder #(
    parameter logic [31:0] SEED     = 32'h0000038C,
    parameter int          WARMUP   = 4,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_imem_req_valid,
    input  logic [31:0] io_imem_req_bits_addr,
    output logic        io_imem_req_ready,
    output logic        io_imem_resp_valid,
    output logic [31:0] io_imem_resp_bits_data,
    output logic [31:0] io_imem_resp_bits_addr,
    input  logic        io_imem_resp_ready,
    output logic [31:0] io_instr_count
);
    localparam logic [7:0] W_WARMUP = WARMUP[7:0];

    logic [1:0]  r_count;
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [31:0] r_addr [2];
    logic [31:0] r_data [2];
    logic [31:0] r_lfsr;
    logic [7:0]  r_warm;
    logic [31:0] r_instr_count;
    logic        r_req_ready;

    logic        w_accept;
    logic        w_deliver;
    logic        w_in_warm;
    logic [31:0] w_lfsr_next;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_rtype;
    logic [31:0] w_word;
    logic [1:0]  w_count_next;

    assign w_accept  = io_imem_req_valid && r_req_ready;
    assign w_deliver = (r_count != 2'd0) && io_imem_resp_ready;
    assign w_in_warm = (r_warm < W_WARMUP);

    assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ 32'h80200003) : (r_lfsr >> 1);

    // The word is decoded from the state the LFSR is about to take, not the current one.
    assign w_funct3 = w_lfsr_next[7:5];
    assign w_funct7 = (w_lfsr_next[18] && (w_funct3 == 3'd0 || w_funct3 == 3'd5)) ? 7'h20 : 7'h00;
    assign w_rtype  = {w_funct7, w_lfsr_next[17:13], w_lfsr_next[12:8], w_funct3,
                       w_lfsr_next[4:0], 7'b0110011};
    assign w_word   = w_in_warm ? NOP_WORD : w_rtype;

    always_comb begin
        w_count_next = r_count;
        if (w_accept && !w_deliver) begin
            w_count_next = r_count + 2'd1;
        end else if (!w_accept && w_deliver) begin
            w_count_next = r_count - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count       <= 2'd0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_lfsr        <= SEED;
            r_warm        <= 8'd0;
            r_instr_count <= 32'd0;
            r_req_ready   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_addr[i] <= 32'd0;
                r_data[i] <= 32'd0;
            end
        end else begin
            r_count <= w_count_next;
            // Registered from the next count so ready never sees resp_ready combinationally.
            r_req_ready <= (w_count_next < 2'd2);
            if (w_deliver) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_accept) begin
                r_wr_ptr         <= ~r_wr_ptr;
                r_addr[r_wr_ptr] <= io_imem_req_bits_addr;
                r_data[r_wr_ptr] <= w_word;
                if (w_in_warm) begin
                    r_warm <= r_warm + 8'd1;
                end else begin
                    r_lfsr        <= w_lfsr_next;
                    r_instr_count <= r_instr_count + 32'd1;
                end
            end
        end
    end

    assign io_imem_req_ready      = r_req_ready;
    assign io_imem_resp_valid     = (r_count != 2'd0);
    assign io_imem_resp_bits_data = r_data[r_rd_ptr];
    assign io_imem_resp_bits_addr = r_addr[r_rd_ptr];
    assign io_instr_count         = r_instr_count;
endmodule

// File: tb/tb_imem_rtype_responder.sv
// Directed bench for imem_rtype_responder: default-warmup and zero-warmup instances
// share stimulus; later phases track the default instance with a small reference model.
module tb_imem_rtype_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic        resp_ready = 1'b0;

    logic        req_ready, resp_valid, req_ready0, resp_valid0;
    logic [31:0] resp_data, resp_addr, instr_count;
    logic [31:0] resp_data0, resp_addr0, instr_count0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_rtype_responder dut (
        .clk(clk), .reset(reset),
        .io_imem_req_valid(req_valid), .io_imem_req_bits_addr(req_addr),
        .io_imem_req_ready(req_ready), .io_imem_resp_valid(resp_valid),
        .io_imem_resp_bits_data(resp_data), .io_imem_resp_bits_addr(resp_addr),
        .io_imem_resp_ready(resp_ready), .io_instr_count(instr_count)
    );

    imem_rtype_responder #(.WARMUP(0)) dut0 (
        .clk(clk), .reset(reset),
        .io_imem_req_valid(req_valid), .io_imem_req_bits_addr(req_addr),
        .io_imem_req_ready(req_ready0), .io_imem_resp_valid(resp_valid0),
        .io_imem_resp_bits_data(resp_data0), .io_imem_resp_bits_addr(resp_addr0),
        .io_imem_resp_ready(resp_ready), .io_instr_count(instr_count0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    function automatic logic [31:0] decode(input logic [31:0] s);
        logic [6:0] f7;
        f7 = (s[18] && (s[7:5] == 3'd0 || s[7:5] == 3'd5)) ? 7'h20 : 7'h00;
        return {f7, s[17:13], s[12:8], s[7:5], s[4:0], 7'b0110011};
    endfunction

    logic [31:0] m_lfsr;
    logic [31:0] m_cnt;
    logic [31:0] q_data[$];
    logic [31:0] q_addr[$];

    // One modelled cycle: predict handshakes from pre-edge values, then compare.
    task automatic model_cycle(input string tag);
        logic acc, del;
        logic [31:0] ed, ea;
        acc = req_valid && req_ready;
        del = resp_valid && resp_ready;
        if (del) begin
            ed = q_data.pop_front();
            ea = q_addr.pop_front();
            chk({tag, "_data"}, resp_data, ed);
            chk({tag, "_addr"}, resp_addr, ea);
            chk({tag, "_opc"}, {25'd0, resp_data[6:0]}, 32'h33);
            chk({tag, "_f7"}, {31'd0, (resp_data[31:25] == 7'h00) ||
                (resp_data[31:25] == 7'h20 && (resp_data[14:12] == 3'd0 || resp_data[14:12] == 3'd5))}, 32'd1);
        end
        if (acc) begin
            m_lfsr = lfsr_adv(m_lfsr);
            m_cnt  = m_cnt + 32'd1;
            q_data.push_back(decode(m_lfsr));
            q_addr.push_back(req_addr);
        end
        step();
        chk({tag, "_cnt"}, instr_count, m_cnt);
        chk({tag, "_valid"}, {31'd0, resp_valid}, {31'd0, q_data.size() != 0});
        chk({tag, "_ready"}, {31'd0, req_ready}, {31'd0, q_data.size() < 2});
    endtask

    logic [31:0] exp_def [5];
    initial begin
        exp_def[0] = 32'h13; exp_def[1] = 32'h13; exp_def[2] = 32'h13;
        exp_def[3] = 32'h13; exp_def[4] = 32'h0000E333;

        // Reset state
        step();
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_data", resp_data, 32'd0);
        chk("rst_addr", resp_addr, 32'd0);
        chk("rst_cnt", instr_count, 32'd0);
        reset = 1'b0;
        req_valid = 1'b1;
        resp_ready = 1'b1;
        req_addr = 32'h1000;
        step();
        chk("ready_rise", {31'd0, req_ready}, 32'd1);
        chk("no_early_resp", {31'd0, resp_valid}, 32'd0);

        // Streaming: default warmup of 4 NOPs, zero-warmup instance straight to R-type
        for (int i = 0; i < 5; i++) begin
            req_addr = 32'h1000 + 32'(4 * i);
            step();
            $display("stream %0d: data=%h addr=%h cnt=%0d | w0 data=%h cnt=%0d",
                     i, resp_data, resp_addr, instr_count, resp_data0, instr_count0);
            chk("stream_valid", {31'd0, resp_valid}, 32'd1);
            chk("stream_data", resp_data, exp_def[i]);
            chk("stream_addr", resp_addr, 32'h1000 + 32'(4 * i));
            chk("stream_cnt", instr_count, (i == 4) ? 32'd1 : 32'd0);
            if (i == 0) begin
                chk("w0_data0", resp_data0, 32'h0000E333);
                chk("w0_cnt0", instr_count0, 32'd1);
            end
            if (i == 1) begin
                chk("w0_data1", resp_data0, 32'h000071B3);
                chk("w0_cnt1", instr_count0, 32'd2);
            end
        end
        req_valid = 1'b0;
        step();
        chk("drain_empty", {31'd0, resp_valid}, 32'd0);

        // Backpressure: fill to 2, hold, then drain in order
        resp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr = 32'h2000;
        step();
        chk("bp_data_a", resp_data, 32'h000071B3);
        chk("bp_ready_a", {31'd0, req_ready}, 32'd1);
        req_addr = 32'h2004;
        step();
        chk("bp_full_ready", {31'd0, req_ready}, 32'd0);
        chk("bp_cnt", instr_count, 32'd3);
        for (int i = 0; i < 2; i++) begin
            req_addr = 32'h3000;
            step();
            $display("hold %0d: data=%h addr=%h ready=%b", i, resp_data, resp_addr, req_ready);
            chk("hold_data", resp_data, 32'h000071B3);
            chk("hold_addr", resp_addr, 32'h2000);
            chk("hold_ready", {31'd0, req_ready}, 32'd0);
            chk("hold_cnt", instr_count, 32'd3);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        step();
        chk("drain_b_data", resp_data, 32'h00003933);
        chk("drain_b_addr", resp_addr, 32'h2004);
        chk("drain_b_ready", {31'd0, req_ready}, 32'd1);
        step();
        chk("drain_done", {31'd0, resp_valid}, 32'd0);

        // Model-tracked phases: LFSR has advanced 3 times so far
        m_lfsr = lfsr_adv(lfsr_adv(lfsr_adv(32'h0000038C)));
        m_cnt = 32'd3;
        req_valid = 1'b1;
        resp_ready = 1'b0;
        req_addr = 32'h4000;
        model_cycle("prime");
        chk("prime_data", resp_data, 32'h00001CB3);
        resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req_addr = 32'h4004 + 32'(4 * i);
            model_cycle("simul");
            $display("simul %0d: data=%h addr=%h cnt=%0d", i, resp_data, resp_addr, instr_count);
        end
        for (int i = 0; i < 300; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            resp_ready = 1'($urandom_range(0, 1));
            req_addr = $urandom;
            model_cycle("rand");
        end
        $display("random phase done: instr_count=%0d", instr_count);

        // Asynchronous reset with FIFO full
        req_valid = 1'b1;
        resp_ready = 1'b0;
        step();
        step();
        chk("prefull_ready", {31'd0, req_ready}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, resp_valid}, 32'd0);
        chk("arst_ready", {31'd0, req_ready}, 32'd0);
        chk("arst_cnt", instr_count, 32'd0);
        chk("arst_data", resp_data, 32'd0);
        step();
        reset = 1'b0;
        resp_ready = 1'b1;
        req_addr = 32'h5000;
        step();
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        step();
        $display("post reset: data=%h addr=%h", resp_data, resp_addr);
        chk("post_rst_data", resp_data, 32'h00000013);
        chk("post_rst_addr", resp_addr, 32'h5000);
        chk("post_rst_cnt", instr_count, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
